sad_pe_array: RTL and testbench

Parametrised successor of the fixed 8x8 motion-estimation PE.
- Takes one row of current-block and reference-block pixels per beat, computes per-lane absolute differences, reduces each row with an adder, and accumulates BEATS rows into one candidate-block SAD.
- Adds a valid/ready input handshake, pause, synchronous clear and a candidate index.
- Sits between the search-window fetch logic and the motion-vector decision logic.

---
 rtl/sad_pe_array_if.sv | 38 +++
 rtl/sad_pe_array.sv | 146 ++++++++++++++
 tb/tb_sad_pe_array.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_pe_array_if.sv
// Bus bundle for sad_pe_array: row-beat input handshake, pause/clear
// controls and the block-SAD result outputs.
// master = search-window fetch side, slave = the PE array.
interface sad_pe_array_if #(
  parameter int COLS   = 8,
  parameter int PIX_W  = 8,
  parameter int BEATS  = 8,
  parameter int CAND_W = 10
);
  localparam int SAD_W = PIX_W + $clog2(COLS * BEATS);

  // Beat handshake: a row beat is transferred on a clock edge where
  // in_valid && in_ready. in_ready depends only on pause and clear, never
  // on in_valid. The master keeps cur_row/ref_row stable while in_valid is
  // high and in_ready is low. out_valid is a one-cycle pulse with no
  // back-pressure; out_sad/out_cand hold until the next pulse.
  logic                   clear;
  logic                   pause;
  logic                   in_valid;
  logic                   in_ready;
  logic [COLS*PIX_W-1:0]  cur_row;
  logic [COLS*PIX_W-1:0]  ref_row;
  logic                   out_valid;
  logic [SAD_W-1:0]       out_sad;
  logic [CAND_W-1:0]      out_cand;
  logic [SAD_W-1:0]       best_sad;
  logic [CAND_W-1:0]      best_cand;

  modport master (
    output clear, pause, in_valid, cur_row, ref_row,
    input  in_ready, out_valid, out_sad, out_cand, best_sad, best_cand
  );

  modport slave (
    input  clear, pause, in_valid, cur_row, ref_row,
    output in_ready, out_valid, out_sad, out_cand, best_sad, best_cand
  );
endinterface

// File: rtl/sad_pe_array.sv
// sad_pe_array: row-parallel sum-of-absolute-differences engine.
// S1 registers per-lane |cur-ref|, S2 registers the row sum, S3 accumulates
// BEATS rows and emits one SAD per candidate block with its index.
// Optional macro SAD_MIN_TRACK_EN adds a running minimum-SAD tracker;
// without it best_sad is all ones and best_cand is zero.
module sad_pe_array #(
  parameter int COLS   = 8,
  parameter int PIX_W  = 8,
  parameter int BEATS  = 8,
  parameter int CAND_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  sad_pe_array_if.slave bus
);
  localparam int SAD_W = PIX_W + $clog2(COLS * BEATS);
  localparam int RS_W  = PIX_W + $clog2(COLS);
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

  logic              accept;
  logic [PIX_W-1:0]  diff_d [COLS];
  logic [PIX_W-1:0]  diff_q [COLS];
  logic              v1_q;
  logic [RS_W-1:0]   rs_d;
  logic [RS_W-1:0]   rs_q;
  logic              v2_q;
  logic [BC_W-1:0]   beat_cnt_q;
  logic [SAD_W-1:0]  acc_q;
  logic [SAD_W-1:0]  blk_sad;
  logic              blk_done;
  logic [CAND_W-1:0] cand_cnt_q;
  logic [SAD_W-1:0]  out_sad_q;
  logic [CAND_W-1:0] out_cand_q;
  logic              out_valid_q;

  assign bus.in_ready = !bus.pause && !bus.clear;
  assign accept       = bus.in_valid && bus.in_ready;

  // Per-lane unsigned absolute difference of the presented row.
  always_comb begin
    for (int i = 0; i < COLS; i++) begin
      diff_d[i] = '0;
      if (bus.cur_row[i*PIX_W +: PIX_W] >= bus.ref_row[i*PIX_W +: PIX_W])
        diff_d[i] = bus.cur_row[i*PIX_W +: PIX_W] - bus.ref_row[i*PIX_W +: PIX_W];
      else
        diff_d[i] = bus.ref_row[i*PIX_W +: PIX_W] - bus.cur_row[i*PIX_W +: PIX_W];
    end
  end

  // Row reduction of the registered lane differences.
  always_comb begin
    rs_d = '0;
    for (int i = 0; i < COLS; i++) rs_d = rs_d + RS_W'(diff_q[i]);
  end

  // The first beat of a block starts from rs alone, so BEATS==1 needs no
  // special case: beat 0 is then also the last beat.
  assign blk_sad  = (beat_cnt_q == '0) ? SAD_W'(rs_q) : acc_q + SAD_W'(rs_q);
  assign blk_done = v2_q && (beat_cnt_q == LAST_BEAT);

  // S1: capture lane differences of an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      diff_q <= '{default: '0};
    end else if (bus.clear) begin
      v1_q <= 1'b0;
    end else if (!bus.pause) begin
      v1_q <= accept;
      if (accept) diff_q <= diff_d;
    end
  end

  // S2: register the row sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
      rs_q <= '0;
    end else if (bus.clear) begin
      v2_q <= 1'b0;
    end else if (!bus.pause) begin
      v2_q <= v1_q;
      if (v1_q) rs_q <= rs_d;
    end
  end

  // S3: accumulate rows, emit the block SAD and advance the candidate index.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      cand_cnt_q  <= '0;
      out_sad_q   <= '0;
      out_cand_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      cand_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.pause) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (v2_q) begin
        acc_q <= blk_sad;
        if (blk_done) begin
          out_sad_q   <= blk_sad;
          out_cand_q  <= cand_cnt_q;
          out_valid_q <= 1'b1;
          beat_cnt_q  <= '0;
          cand_cnt_q  <= cand_cnt_q + CAND_W'(1);
        end else begin
          beat_cnt_q <= beat_cnt_q + BC_W'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sad   = out_sad_q;
  assign bus.out_cand  = out_cand_q;

`ifdef SAD_MIN_TRACK_EN
  logic [SAD_W-1:0]  best_sad_q;
  logic [CAND_W-1:0] best_cand_q;

  // Running minimum; strict compare so ties keep the earlier candidate.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      best_sad_q  <= '1;
      best_cand_q <= '0;
    end else if (!bus.pause && blk_done && (blk_sad < best_sad_q)) begin
      best_sad_q  <= blk_sad;
      best_cand_q <= cand_cnt_q;
    end
  end

  assign bus.best_sad  = best_sad_q;
  assign bus.best_cand = best_cand_q;
`else
  assign bus.best_sad  = '1;
  assign bus.best_cand = '0;
`endif
endmodule

// File: tb/tb_sad_pe_array.sv
// Bench for sad_pe_array. A second instance with CAND_W=2 sees the same
// stimulus and shows the candidate index wrap.
module tb_sad_pe_array;
  localparam int COLS   = 8;
  localparam int PIX_W  = 8;
  localparam int BEATS  = 8;
  localparam int CAND_W = 10;
  localparam int ROW_W  = COLS * PIX_W;
  localparam int SAD_W  = PIX_W + $clog2(COLS * BEATS);
  localparam int EXP_W  = SAD_W + CAND_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulse_count = 0;
  int   last_pulse_cyc = 0;
  int   prev_pulse_cyc = 0;
  logic [SAD_W-1:0] last_exp_sad = '0;

  // scoreboard: {sad, cand, cand mod 4}
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;

  // reference model state
  int                m_acc;
  int                m_beats;
  logic [CAND_W-1:0] m_cand;
  logic [SAD_W-1:0]  m_best;
  logic [CAND_W-1:0] m_best_cand;

  sad_pe_array_if #(.COLS(COLS), .PIX_W(PIX_W), .BEATS(BEATS), .CAND_W(CAND_W)) intf ();
  sad_pe_array_if #(.COLS(COLS), .PIX_W(PIX_W), .BEATS(BEATS), .CAND_W(2))      intf2 ();

  assign intf2.clear    = intf.clear;
  assign intf2.pause    = intf.pause;
  assign intf2.in_valid = intf.in_valid;
  assign intf2.cur_row  = intf.cur_row;
  assign intf2.ref_row  = intf.ref_row;

  sad_pe_array #(.COLS(COLS), .PIX_W(PIX_W), .BEATS(BEATS), .CAND_W(CAND_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  sad_pe_array #(.COLS(COLS), .PIX_W(PIX_W), .BEATS(BEATS), .CAND_W(2)) u_dut_w2 (
    .clk (clk),
    .rst (rst),
    .bus (intf2)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic int row_sad(input logic [ROW_W-1:0] c, input logic [ROW_W-1:0] r);
    int s;
    int a;
    int b;
    s = 0;
    for (int i = 0; i < COLS; i++) begin
      a = int'(c[i*PIX_W +: PIX_W]);
      b = int'(r[i*PIX_W +: PIX_W]);
      s = s + ((a > b) ? a - b : b - a);
    end
    return s;
  endfunction

  function automatic logic [ROW_W-1:0] fill(input int v);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < COLS; i++) r[i*PIX_W +: PIX_W] = PIX_W'(v);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < COLS; i++) r[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic model_reset();
    m_acc       = 0;
    m_beats     = 0;
    m_cand      = '0;
    m_best      = '1;
    m_best_cand = '0;
    exp_q.delete();
  endtask

  task automatic model_beat(input logic [ROW_W-1:0] c, input logic [ROW_W-1:0] r);
    logic [SAD_W-1:0] s;
    m_acc   = m_acc + row_sad(c, r);
    m_beats = m_beats + 1;
    if (m_beats == BEATS) begin
      s = SAD_W'(m_acc);
      exp_q.push_back({s, m_cand, m_cand[1:0]});
`ifdef SAD_MIN_TRACK_EN
      if (s < m_best) begin
        m_best      = s;
        m_best_cand = m_cand;
      end
`endif
      m_cand  = m_cand + CAND_W'(1);
      m_acc   = 0;
      m_beats = 0;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (intf2.out_valid !== intf.out_valid) begin
        n_fail++;
        $display("FAIL w2_valid got %b required %b", intf2.out_valid, intf.out_valid);
      end
      if (intf.out_valid === 1'b1) begin
        pulse_count++;
        prev_pulse_cyc = last_pulse_cyc;
        last_pulse_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse cyc=%0d sad=%0d cand=%0d", cyc, intf.out_sad, intf.out_cand);
        end else begin
          mon_e = exp_q.pop_front();
          last_exp_sad = mon_e[EXP_W-1 -: SAD_W];
          if (intf.out_sad !== mon_e[EXP_W-1 -: SAD_W]) begin
            n_fail++;
            $display("FAIL sb_sad got %0d required %0d", intf.out_sad, mon_e[EXP_W-1 -: SAD_W]);
          end
          n_checks++;
          if (intf.out_cand !== mon_e[CAND_W+1 -: CAND_W]) begin
            n_fail++;
            $display("FAIL sb_cand got %0d required %0d", intf.out_cand, mon_e[CAND_W+1 -: CAND_W]);
          end
          n_checks++;
          if (intf2.out_cand !== mon_e[1:0]) begin
            n_fail++;
            $display("FAIL sb_cand_w2 got %0d required %0d", intf2.out_cand, mon_e[1:0]);
          end
          n_checks++;
          if (intf2.out_sad !== mon_e[EXP_W-1 -: SAD_W]) begin
            n_fail++;
            $display("FAIL sb_sad_w2 got %0d required %0d", intf2.out_sad, mon_e[EXP_W-1 -: SAD_W]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic v, input logic [ROW_W-1:0] c, input logic [ROW_W-1:0] r,
                             input logic p, input logic clr);
    intf.in_valid = v;
    intf.cur_row  = c;
    intf.ref_row  = r;
    intf.pause    = p;
    intf.clear    = clr;
    #1;
    n_checks++;
    if (intf.in_ready !== (!p && !clr)) begin
      n_fail++;
      $display("FAIL in_ready got %b required %b (pause=%b clear=%b)", intf.in_ready, !p && !clr, p, clr);
    end
    if (clr) model_reset();
    else if (v && !p) model_beat(c, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      idle_cycle();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    idle_cycle();
    n_checks++;
    if (intf.best_sad !== m_best || intf.best_cand !== m_best_cand) begin
      n_fail++;
      $display("FAIL best_model got %0d/%0d required %0d/%0d", intf.best_sad, intf.best_cand, m_best, m_best_cand);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    intf.in_valid = 1'b0;
    intf.pause    = 1'b0;
    intf.clear    = 1'b0;
    intf.cur_row  = '0;
    intf.ref_row  = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    n_checks++;
    if (intf.out_valid !== 1'b0 || intf.out_sad !== '0 || intf.out_cand !== '0) begin
      n_fail++;
      $display("FAIL reset_out got v=%b sad=%0d cand=%0d required 0/0/0", intf.out_valid, intf.out_sad, intf.out_cand);
    end
    n_checks++;
    if (intf.best_sad !== {SAD_W{1'b1}} || intf.best_cand !== '0) begin
      n_fail++;
      $display("FAIL reset_best got %0d/%0d required %0d/0", intf.best_sad, intf.best_cand, {SAD_W{1'b1}});
    end
    n_checks++;
    if (intf2.out_valid !== 1'b0 || intf2.out_cand !== '0) begin
      n_fail++;
      $display("FAIL reset_w2 got v=%b cand=%0d required 0/0", intf2.out_valid, intf2.out_cand);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_stream();
    int t_last;
    int base;
    logic [ROW_W-1:0] row;
    base = pulse_count;
    t_last = 0;
    for (int b = 0; b < BEATS; b++) begin
      if (b == BEATS - 1) t_last = cyc;
      drive_cycle(1'b1, fill(255), fill(0), 1'b0, 1'b0);
    end
    for (int b = 0; b < BEATS; b++) begin
      row = rand_row();
      drive_cycle(1'b1, row, row, 1'b0, 1'b0);
    end
    wait_drain(20);
    n_checks++;
    if (pulse_count - base != 2) begin
      n_fail++;
      $display("FAIL stream_pulses got %0d required 2", pulse_count - base);
    end
    n_checks++;
    if (prev_pulse_cyc - t_last != 3) begin
      n_fail++;
      $display("FAIL stream_latency got %0d required 3", prev_pulse_cyc - t_last);
    end
    n_checks++;
    if (last_pulse_cyc - prev_pulse_cyc != BEATS) begin
      n_fail++;
      $display("FAIL stream_spacing got %0d required %0d", last_pulse_cyc - prev_pulse_cyc, BEATS);
    end
    n_checks++;
    if (intf.out_sad !== 14'd0 || intf.out_cand !== 10'd1) begin
      n_fail++;
      $display("FAIL stream_hold got %0d/%0d required 0/1", intf.out_sad, intf.out_cand);
    end
  endtask

  task automatic test_pause();
    int first;
    int t_last;
    int base;
    base  = pulse_count;
    first = cyc;
    for (int b = 0; b < 3; b++) drive_cycle(1'b1, fill(2), fill(0), 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) drive_cycle(1'b1, fill(2), fill(0), 1'b1, 1'b0);
    for (int b = 3; b < BEATS; b++) drive_cycle(1'b1, fill(2), fill(0), 1'b0, 1'b0);
    wait_drain(20);
    n_checks++;
    if (last_pulse_cyc - first != 12) begin
      n_fail++;
      $display("FAIL pause_latency got %0d required 12", last_pulse_cyc - first);
    end
    n_checks++;
    if (pulse_count - base != 1 || intf.out_sad !== 14'd128) begin
      n_fail++;
      $display("FAIL pause_single got pulses=%0d sad=%0d required 1/128", pulse_count - base, intf.out_sad);
    end
    // pause while the completing block is still in flight
    base = pulse_count;
    t_last = 0;
    for (int b = 0; b < BEATS; b++) begin
      if (b == BEATS - 1) t_last = cyc;
      drive_cycle(1'b1, fill(1), fill(0), 1'b0, 1'b0);
    end
    for (int p = 0; p < 3; p++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    wait_drain(20);
    n_checks++;
    if (last_pulse_cyc - t_last != 6 || pulse_count - base != 1) begin
      n_fail++;
      $display("FAIL pause_tail got lat=%0d pulses=%0d required 6/1", last_pulse_cyc - t_last, pulse_count - base);
    end
  endtask

  task automatic test_clear();
    int base;
    logic [SAD_W-1:0] held;
    held = last_exp_sad;
    base = pulse_count;
    for (int b = 0; b < 5; b++) drive_cycle(1'b1, fill(4), fill(1), 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    drive_cycle(1'b1, fill(9), fill(0), 1'b0, 1'b1);
    n_checks++;
    if (intf.out_sad !== held || intf.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_hold got sad=%0d v=%b required %0d/0", intf.out_sad, intf.out_valid, held);
    end
    for (int b = 0; b < BEATS; b++) drive_cycle(1'b1, fill(10), fill(11), 1'b0, 1'b0);
    wait_drain(20);
    n_checks++;
    if (pulse_count - base != 1 || intf.out_sad !== 14'd64 || intf.out_cand !== 10'd0) begin
      n_fail++;
      $display("FAIL clear_block got pulses=%0d sad=%0d cand=%0d required 1/64/0",
               pulse_count - base, intf.out_sad, intf.out_cand);
    end
  endtask

  task automatic send_block_lane(input int v0, input int v1);
    logic [ROW_W-1:0] row;
    row = '0;
    row[PIX_W-1:0]       = PIX_W'(v0);
    row[2*PIX_W-1:PIX_W] = PIX_W'(v1);
    drive_cycle(1'b1, row, '0, 1'b0, 1'b0);
    for (int b = 1; b < BEATS; b++) drive_cycle(1'b1, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_min_track();
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
    send_block_lane(250, 250);
    send_block_lane(200, 0);
    send_block_lane(0, 200);
    wait_drain(20);
    n_checks++;
`ifdef SAD_MIN_TRACK_EN
    if (intf.best_sad !== 14'd200 || intf.best_cand !== 10'd1) begin
      n_fail++;
      $display("FAIL min_track got %0d/%0d required 200/1", intf.best_sad, intf.best_cand);
    end
`else
    if (intf.best_sad !== 14'd16383 || intf.best_cand !== 10'd0) begin
      n_fail++;
      $display("FAIL min_track got %0d/%0d required 16383/0", intf.best_sad, intf.best_cand);
    end
`endif
  endtask

  task automatic test_reset_mid_block();
    for (int b = 0; b < 4; b++) drive_cycle(1'b1, fill(5), fill(0), 1'b0, 1'b0);
    do_reset();
    for (int b = 0; b < BEATS; b++) drive_cycle(1'b1, fill(3), fill(6), 1'b0, 1'b0);
    wait_drain(20);
    n_checks++;
    if (intf.out_sad !== 14'd192 || intf.out_cand !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid got %0d/%0d required 192/0", intf.out_sad, intf.out_cand);
    end
  endtask

  task automatic test_cand_wrap();
    do_reset();
    for (int k = 0; k < 5; k++)
      for (int b = 0; b < BEATS; b++) drive_cycle(1'b1, rand_row(), rand_row(), 1'b0, 1'b0);
    wait_drain(20);
    n_checks++;
    if (intf2.out_cand !== 2'd0 || intf.out_cand !== 10'd4) begin
      n_fail++;
      $display("FAIL cand_wrap got w2=%0d main=%0d required 0/4", intf2.out_cand, intf.out_cand);
    end
  endtask

  task automatic test_random();
    logic v;
    logic p;
    for (int n = 0; n < 80; n++) begin
      v = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 5) == 0);
      drive_cycle(v, rand_row(), rand_row(), p, 1'b0);
    end
    wait_drain(30);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_pause();
    test_clear();
    test_min_track();
    test_reset_mid_block();
    test_cand_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
